// File: rtl/led_pattern_gen_if.sv
// Board-side bundle of the LED pattern generator: mode switches in, LED bank and step pulse out.
interface led_pattern_gen_if #(
    parameter int N_LEDS = 8
);
    logic [1:0]        mode;
    logic [N_LEDS-1:0] leds;
    logic              step;

    modport master (output mode, input leds, input step);
    modport slave  (input mode, output leds, output step);
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator: reset synchroniser, mode synchroniser, prescaler tick and four
// selectable patterns (up, down, bouncing scanner, Gray) on a registered LED bank.
module led_pattern_gen #(
    parameter int N_LEDS     = 8,
    parameter int PRESCALE_W = 24,
    parameter int RST_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_ext,
    led_pattern_gen_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_SCAN = 2'b10,
        MODE_GRAY = 2'b11
    } mode_e;

    logic [RST_STAGES-1:0] r_rst_sync;
    logic                  w_rst;
    mode_e                 r_mode_meta, r_mode_s, r_mode_q;
    logic [PRESCALE_W-1:0] r_pre;
    logic                  w_tick, w_change;
    logic [N_LEDS-1:0]     r_pat, w_pat_next;
    logic [N_LEDS-1:0]     r_leds, w_leds_next;
    logic                  r_dir, w_dir_next;
    logic                  r_step;

    function automatic logic [N_LEDS-1:0] init_pat(input mode_e m);
        case (m)
            MODE_DOWN: return '1;
            MODE_SCAN: return N_LEDS'(1);
            default:   return '0;
        endcase
    endfunction

    // NOTE: rst_ext only ever sets this chain asynchronously; release is clocked, so every
    // other flop sees a clean synchronous reset.
    always_ff @(posedge clk or posedge rst_ext) begin
        if (rst_ext) r_rst_sync <= '1;
        else         r_rst_sync <= {r_rst_sync[RST_STAGES-2:0], 1'b0};
    end

    assign w_rst    = r_rst_sync[RST_STAGES-1];
    assign w_tick   = &r_pre;
    assign w_change = (r_mode_s != r_mode_q);

    // A reload wins over a coincident tick, so a mode change never produces a step.
    always_comb begin
        w_pat_next = r_pat;
        w_dir_next = r_dir;
        if (w_change) begin
            w_pat_next = init_pat(r_mode_s);
            w_dir_next = 1'b0;
        end else if (w_tick) begin
            case (r_mode_s)
                MODE_DOWN: w_pat_next = r_pat - N_LEDS'(1);
                MODE_SCAN: begin
                    if (r_pat == '0) begin
                        w_pat_next = N_LEDS'(1);
                        w_dir_next = 1'b0;
                    end else if (!r_dir) begin
                        if (r_pat[N_LEDS-1]) begin
                            w_pat_next = r_pat >> 1;
                            w_dir_next = 1'b1;
                        end else begin
                            w_pat_next = r_pat << 1;
                        end
                    end else begin
                        if (r_pat[0]) begin
                            w_pat_next = r_pat << 1;
                            w_dir_next = 1'b0;
                        end else begin
                            w_pat_next = r_pat >> 1;
                        end
                    end
                end
                default:   w_pat_next = r_pat + N_LEDS'(1);
            endcase
        end
        w_leds_next = (r_mode_s == MODE_GRAY) ? (w_pat_next ^ (w_pat_next >> 1)) : w_pat_next;
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_mode_meta <= MODE_UP;
            r_mode_s    <= MODE_UP;
            r_mode_q    <= MODE_UP;
            r_pre       <= '0;
            r_pat       <= '0;
            r_dir       <= 1'b0;
            r_leds      <= '0;
            r_step      <= 1'b0;
        end else begin
            r_mode_meta <= mode_e'(bus.mode);
            r_mode_s    <= r_mode_meta;
            r_mode_q    <= r_mode_s;
            r_pre       <= w_change ? '0 : r_pre + PRESCALE_W'(1);
            r_pat       <= w_pat_next;
            r_dir       <= w_dir_next;
            r_leds      <= w_leds_next;
            r_step      <= w_tick && !w_change;
        end
    end

    assign bus.leds = r_leds;
    assign bus.step = r_step;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with N_LEDS=8, PRESCALE_W=4, RST_STAGES=2.
module tb_led_pattern_gen;
    logic clk = 1'b0;
    logic rst_ext;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n;

    led_pattern_gen_if #(.N_LEDS(8)) bus ();

    led_pattern_gen #(
        .N_LEDS    (8),
        .PRESCALE_W(4),
        .RST_STAGES(2)
    ) dut (
        .clk    (clk),
        .rst_ext(rst_ext),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Counts falling edges until step is seen high, bounded.
    task automatic wait_step(input int bound, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.step && cycles < bound);
        if (!bus.step) check("step_timeout", 32'(bus.step), 32'd1);
    endtask

    task automatic reload_to(input logic [1:0] m, input logic [7:0] exp, input string tag);
        bus.mode = m;
        repeat (3) begin
            @(negedge clk);
            check({tag, "_no_step"}, 32'(bus.step), 32'd0);
        end
        check({tag, "_reload"}, 32'(bus.leds), 32'(exp));
    endtask

    logic [7:0] scan_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] gray_exp [7]  = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04};
    logic [7:0] prev;

    initial begin
        bus.mode = 2'b00;
        rst_ext  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_leds", 32'(bus.leds), 32'd0);
        check("rst_step", 32'(bus.step), 32'd0);

        // Up mode from reset release, including the 0xFF -> 0x00 wrap.
        rst_ext = 1'b0;
        wait_step(40, n);
        check("up_first_latency", 32'(n), 32'd18);
        check("up_first_leds", 32'(bus.leds), 32'h01);
        for (int i = 2; i <= 256; i++) begin
            wait_step(40, n);
            check("up_period", 32'(n), 32'd16);
            check("up_count", 32'(bus.leds), 32'(i % 256));
        end

        reload_to(2'b01, 8'hFF, "down");
        wait_step(40, n);
        check("down_period", 32'(n), 32'd16);
        check("down_leds", 32'(bus.leds), 32'hFE);

        reload_to(2'b10, 8'h01, "scan");
        for (int i = 0; i < 15; i++) begin
            wait_step(40, n);
            check("scan_period", 32'(n), 32'd16);
            check("scan_leds", 32'(bus.leds), 32'(scan_exp[i]));
        end

        reload_to(2'b11, 8'h00, "gray");
        prev = bus.leds;
        for (int i = 0; i < 7; i++) begin
            wait_step(40, n);
            check("gray_period", 32'(n), 32'd16);
            check("gray_leds", 32'(bus.leds), 32'(gray_exp[i]));
            check("gray_one_bit", 32'($countones(prev ^ bus.leds)), 32'd1);
            prev = bus.leds;
        end

        // Line the mode_s change up with the pre == 15 cycle.
        repeat (13) @(negedge clk);
        reload_to(2'b00, 8'h00, "coinc");
        wait_step(40, n);
        check("coinc_period", 32'(n), 32'd16);
        check("coinc_leds", 32'(bus.leds), 32'h01);

        reload_to(2'b10, 8'h01, "arst");
        for (int i = 0; i < 4; i++) begin
            wait_step(40, n);
            check("arst_scan_leds", 32'(bus.leds), 32'(scan_exp[i]));
        end
        #1 rst_ext = 1'b1;
        #3 rst_ext = 1'b0;
        @(negedge clk);
        check("arst_leds", 32'(bus.leds), 32'd0);
        check("arst_step", 32'(bus.step), 32'd0);
        wait_step(40, n);
        check("arst_restart_latency", 32'(n), 32'd20);
        check("arst_restart_leds", 32'(bus.leds), 32'h02);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator for board bring-up and demo designs: the next generation of the free-running LED counter. It synchronises an external asynchronous reset and divides `clk` with a prescaler to produce a step tick. On each tick it advances one of four selectable LED patterns: binary up, binary down, bouncing scanner or Gray-code count. It sits directly between board pins (clock, reset button, mode switches) and the LED bank.

## Interface
- `N_LEDS`, 8: LED count and pattern width; legal range 2..32.
- `PRESCALE_W`, 24: prescaler width; step period is 2^PRESCALE_W clk cycles; legal range 2..32.
- `RST_STAGES`, 2: reset synchroniser depth; legal range 2..4.
- `clk` in 1: system clock.
- `rst_ext` in 1: asynchronous, active-high reset.
- `mode` in 2: pattern select from switches, asynchronous to `clk`.
  - `00` up
  - `01` down
  - `10` scanner
  - `11` Gray
- `leds` out N_LEDS: registered pattern output.
- `step` out 1: registered one-cycle pulse, high in the cycle where `leds` shows a newly advanced pattern.

## Operation
**Internal reset `rst`**
- Produced by a RST_STAGES-deep shift register.
- Asynchronously set to all ones by `rst_ext`.
- Shifts in 0 on each clk edge once `rst_ext` is low.
- `rst` is the last stage.
- All other logic resets synchronously on `rst`.

**Mode synchroniser**
- Two flops, reset to `00`.
- `mode_s` is the synchronised value. `mode_q` is `mode_s` delayed one cycle, reset `00`.
- A mode change is `mode_s != mode_q`.

**Prescaler `pre`**
- PRESCALE_W-bit up-counter, reset 0, wraps from all-ones to 0.
- `tick` (internal) = `pre` all-ones.

**Pattern state**
- Internal `pat` (N_LEDS bits) and scanner direction `dir` (0 = toward MSB, 1 = toward LSB).
- Initial values per mode, applied on reload:
  - up: 0
  - down: all ones
  - scanner: 1 (bit 0 lit), `dir` = 0
  - Gray: binary 0

**Advance on `tick`** (modulo 2^N_LEDS):
- up: `pat` + 1
- down: `pat` - 1
- scanner: shift one position in `dir`.
  - If the lit bit is at N_LEDS-1 with `dir` = 0, move to N_LEDS-2 and set `dir` = 1.
  - If the lit bit is at bit 0 with `dir` = 1, move to bit 1 and set `dir` = 0.
  - End positions are therefore shown for exactly one step.
- Gray: `pat` + 1 (binary).

**Output mapping**
- `leds` = `pat` in the up, down and scanner modes.
- `leds` = `pat` ^ (`pat` >> 1) in Gray mode.
- `leds` is a registered copy updated on the same edge as `pat`.

**Mode change**
- Reload `pat`/`dir` with the initial value of the new `mode_s`, and clear `pre` to 0.
- A mode change takes priority over a coincident `tick`: no advance and no `step`.

**Reset values**
- `leds` = 0, `step` = 0, `pre` = 0, `pat` = 0, `dir` = 0, `mode_s` = `mode_q` = `00`.

**Reset mid-operation**
- Any `rst_ext` pulse immediately forces `rst` high, asynchronously.
- State returns to reset values on the next clk edge and is held while `rst` is high.

**Scanner recovery**
- If `pat` is not one-hot in scanner mode (only possible via mode reload), the design must still reload correctly.
- In scanner mode `pat` is never zero.

## Timing
- `rst` deasserts on the RST_STAGES-th rising clk edge after `rst_ext` falls. `rst_ext` assertion is seen at outputs on the next clk edge (synchronous clear by `rst`).
- First `tick` occurs 2^PRESCALE_W - 1 cycles after `rst` deasserts. `pre` counts from 0 starting the first cycle with `rst` low.
- On the edge ending a `tick` cycle, `pat`, `leds` and `step` update together. `step` is high for exactly that one following cycle.
- Step period: exactly 2^PRESCALE_W cycles in steady state.
- `mode` input to reload visible on `leds`: 3 clk edges (2 sync flops plus the reload edge). `step` stays low on the reload edge.
- After a reload, the next `tick` comes 2^PRESCALE_W - 1 cycles later.

## Test plan
Use `N_LEDS`=8, `PRESCALE_W`=4, `RST_STAGES`=2 throughout.

1. **Reset release, up mode:** `mode`=`00`, release `rst_ext` → `leds`=0x00 for 2+15 cycles, then `step` pulse with `leds`=0x01; `leds`=0x02 16 cycles later; wraps 0xFF→0x00.
2. **Down mode:** switch `mode` to `01` → `leds`=0xFF 3 edges later; after 15 further cycles `step` fires with `leds`=0xFE.
3. **Scanner bounce:** `mode`=`10` → `leds` sequence 0x01,0x02,…,0x80,0x40,…,0x01,0x02; the 0x80 and 0x01 end positions each last exactly 16 cycles.
4. **Gray mode:** `mode`=`11` → `leds` sequence 0x00,0x01,0x03,0x02,0x06,0x07,0x05,0x04. Exactly one bit changes per `step`.
5. **Mode change coincident with tick:** time the `mode_s` change onto the `pre`=15 cycle → `leds` reloads, no `step`, and the next `step` arrives 16 cycles later.
6. **Async reset mid-run:** pulse `rst_ext` for 3 ns, away from clk edges, in scanner mode at 0x10 → `leds`=0x00 and `step`=0 after the next edge. Counting restarts 2 edges after `rst_ext` falls; the first step shows 0x02 after the `00`→`10` reload.
